imem_fetch: RTL
===============

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter DEPTH, 1024, instruction words stored; power of two, 16..65536; AW = log2(DEPTH).
REQ-002 Parameter XLEN, 32, instruction/address width; fixed at 32 in this generation.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ld_start  in  1  one-cycle pulse; begins a program load at word 0.
REQ-006 ld_valid  in  1  ld_byte is valid this cycle; always accepted, no backpressure.
REQ-007 ld_byte  in  8  program byte, file order.
REQ-008 ld_last  in  1  qualifies ld_valid; marks the final byte of the program.
REQ-009 ld_busy  out  1  high while in state LOAD.
REQ-010 ld_done  out  1  sticky; set when a load completes, cleared by ld_start.
REQ-011 ld_ovf  out  1  sticky; bytes were dropped beyond DEPTH*4, cleared by ld_start.
REQ-012 req_valid / req_ready  in / out  1 / 1  fetch request handshake.
REQ-013 req_addr  in  32  byte address of the instruction.
REQ-014 rsp_valid / rsp_ready  out / in  1 / 1  fetch response handshake.
REQ-015 rsp_instr  out  32  fetched instruction word.
REQ-016 rsp_err  out  1  fetch fault flag; see Configuration.

Function
REQ-017 FSM states:
- RUN: fetch enabled.
- LOAD: fetch blocked.
- RUN->LOAD on ld_start.
- LOAD->RUN on the cycle after the accepted byte with ld_last=1.
REQ-018 ld_start in either state:
- byte pointer := 0, word pointer := 0.
- ld_done := 0, ld_ovf := 0, rsp_valid := 0 (pending response flushed).
- Memory contents are retained.
REQ-019 ld_start and ld_valid in the same cycle: ld_start wins and the byte is discarded.
REQ-020 In LOAD, the k-th accepted byte of a word (k=0..3) lands in bits [8k+7:8k] (little-endian assembly). The word is written to mem[word pointer] on the 4th byte, then the word pointer increments.
REQ-021 ld_last with fewer than 4 bytes assembled: remaining bytes are zero-filled and the word is written in the same cycle.
REQ-022 Bytes arriving when word pointer = DEPTH are dropped and ld_ovf := 1; there is no wrap-around.
REQ-023 ld_done := 1 on the LOAD->RUN transition; ld_valid in RUN is ignored.
REQ-024 req_ready = (state == RUN) && (!rsp_valid || rsp_ready). A request is accepted when req_valid && req_ready.
REQ-025 Latency is 1: a request accepted at edge N gives rsp_valid=1 and rsp_instr = mem[req_addr[AW+1:2]] after edge N+1.
REQ-026 While rsp_valid && !rsp_ready, rsp_instr and rsp_err hold stable and no new request is accepted.
REQ-027 Back-to-back: response consumed and new request accepted in the same cycle gives rsp_valid=1 continuously, one instruction per cycle.
REQ-028 rsp_valid deasserts after a consuming edge when no new request is accepted.
REQ-029 Request in LOAD: req_ready=0; the request remains pending at the source.

Reset
REQ-030 rst=1 asynchronously forces: state=RUN, rsp_valid=0, rsp_instr=0, rsp_err=0, ld_busy=0, ld_done=0, ld_ovf=0, byte and word pointers 0.
REQ-031 Memory array is not reset. Reset during LOAD abandons any partial word (not written).
REQ-032 All outputs are valid from the first edge after rst deasserts.

Configuration
REQ-033 Macro IMEM_FETCH_ERR_EN.
REQ-034 With IMEM_FETCH_ERR_EN defined, rsp_err=1 and rsp_instr=0x00000000 when the accepted req_addr[1:0]!=0 or req_addr >= DEPTH*4; otherwise rsp_err=0.
REQ-035 Without IMEM_FETCH_ERR_EN, rsp_err is tied 0, req_addr[1:0] and bits above AW+1 are ignored, and the address wraps modulo DEPTH*4.

Verification
REQ-036 Load bytes 13 00 00 00 93 00 10 00 (last on 8th), then fetch 0x0 and 0x4 -> 0x00000013 and 0x00100093, each with 1-cycle latency, and ld_done=1.
REQ-037 Load 5 bytes 01 02 03 04 05 (last) -> mem[1]=0x00000005, FSM returns to RUN on the next cycle.
REQ-038 Fetch stream 0x0..0x3C with rsp_ready toggled 1/0 every cycle -> 16 in-order responses, no drops or duplicates, data stable while stalled.
REQ-039 DEPTH=16, load 68 bytes -> ld_ovf=1, mem[0..15] hold the first 64 bytes; then ld_start -> ld_ovf=0, ld_done=0.
REQ-040 ERR_EN: fetch 0x2 and 0x40 (DEPTH=16) -> rsp_err=1, rsp_instr=0. No ERR_EN: fetch 0x40 returns mem[0].
REQ-041 Assert rst mid-LOAD after 2 bytes -> immediate RUN, ld_busy=0, mem unchanged, outputs at reset values.

Source files
------------

// File: rtl/imem_fetch_if.sv
// Load-port and fetch-port signal bundle for imem_fetch.
// master = loader/fetch client side, slave = imem_fetch side.
interface imem_fetch_if #(
    parameter int XLEN = 32
);
    logic            ld_start;
    logic            ld_valid;
    logic [7:0]      ld_byte;
    logic            ld_last;
    logic            ld_busy;
    logic            ld_done;
    logic            ld_ovf;

    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;

    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_instr;
    logic            rsp_err;

    modport master (
        output ld_start, ld_valid, ld_byte, ld_last,
        output req_valid, req_addr, rsp_ready,
        input  ld_busy, ld_done, ld_ovf,
        input  req_ready, rsp_valid, rsp_instr, rsp_err
    );

    modport slave (
        input  ld_start, ld_valid, ld_byte, ld_last,
        input  req_valid, req_addr, rsp_ready,
        output ld_busy, ld_done, ld_ovf,
        output req_ready, rsp_valid, rsp_instr, rsp_err
    );
endinterface

// File: rtl/imem_fetch.sv
// Instruction memory with a byte-stream program loader and a 1-cycle fetch port.
// Optional IMEM_FETCH_ERR_EN flags misaligned / out-of-range fetches via rsp_err.
module imem_fetch #(
    parameter int DEPTH = 1024,
    parameter int XLEN  = 32
) (
    input  logic         clk,
    input  logic         rst,
    imem_fetch_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_t;

    state_t          state;
    logic [XLEN-1:0] mem [DEPTH];

    logic [1:0]      bptr;
    logic [AW:0]     wptr;     // reaches DEPTH exactly when the memory is full
    logic [XLEN-1:0] asm_q;

    logic            ld_busy_q;
    logic            ld_done_q;
    logic            ld_ovf_q;
    logic            rsp_valid_q;
    logic [XLEN-1:0] rsp_instr_q;
    logic            rsp_err_q;

    logic            byte_take;
    logic            room;
    logic            wr_en;
    logic [XLEN-1:0] wr_data;
    logic            req_ready;
    logic            fire;
    logic [AW-1:0]   rd_idx;
    logic            rd_err;

    always_comb begin
        byte_take = (state == LOAD) && bus.ld_valid && !bus.ld_start;
        room      = !wptr[AW];
        wr_data   = asm_q | (XLEN'(bus.ld_byte) << {bptr, 3'b000});
        // A short final word is written with its missing upper bytes still zero.
        wr_en     = byte_take && room && ((bptr == 2'd3) || bus.ld_last);
        req_ready = (state == RUN) && (!rsp_valid_q || bus.rsp_ready);
        fire      = bus.req_valid && req_ready;
        rd_idx    = bus.req_addr[AW+1:2];
    end

`ifdef IMEM_FETCH_ERR_EN
    assign rd_err = (bus.req_addr[1:0] != 2'b00) || (bus.req_addr >= XLEN'(DEPTH * 4));
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[XLEN-1:AW+2], bus.req_addr[1:0]};
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            bptr        <= '0;
            wptr        <= '0;
            asm_q       <= '0;
            ld_busy_q   <= 1'b0;
            ld_done_q   <= 1'b0;
            ld_ovf_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_instr_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (bus.ld_start) begin
            // Restart wins over any byte or fetch this cycle; memory is kept.
            state       <= LOAD;
            bptr        <= '0;
            wptr        <= '0;
            asm_q       <= '0;
            ld_busy_q   <= 1'b1;
            ld_done_q   <= 1'b0;
            ld_ovf_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            if (byte_take) begin
                if (!room) begin
                    ld_ovf_q <= 1'b1;
                end else if (wr_en) begin
                    wptr  <= wptr + (AW+1)'(1);
                    bptr  <= '0;
                    asm_q <= '0;
                end else begin
                    asm_q <= wr_data;
                    bptr  <= bptr + 2'd1;
                end
                if (bus.ld_last) begin
                    state     <= RUN;
                    ld_busy_q <= 1'b0;
                    ld_done_q <= 1'b1;
                end
            end

            if (fire) begin
                rsp_valid_q <= 1'b1;
                rsp_instr_q <= rd_err ? '0 : mem[rd_idx];
                rsp_err_q   <= rd_err;
            end else if (bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.ld_busy   = ld_busy_q;
    assign bus.ld_done   = ld_done_q;
    assign bus.ld_ovf    = ld_ovf_q;
    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_instr = rsp_instr_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule
